// File: rtl/tile_prefetch_loader.sv
// rtl/tile_prefetch_loader.sv - streams tiles into the prefetch bank of a double-buffered tile buffer and swaps banks
module tile_prefetch_loader #(
    parameter int BANK_DEPTH = 256,
    parameter int DATA_W     = 8,
    parameter int TILE_CNT_W = 16,
    localparam int AW        = $clog2(BANK_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [TILE_CNT_W-1:0] num_tiles,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  dma_wr_en,
    output logic [AW-1:0]         dma_wr_addr,
    output logic [DATA_W-1:0]     dma_wr_data,
    output logic                  swap,
    input  logic                  compute_release,
    output logic                  tile_valid
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_SWAP = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(BANK_DEPTH - 1);

    state_t                state;
    logic [TILE_CNT_W-1:0] tiles_left;
    logic [AW-1:0]         addr;
    logic                  swap_fire;
    logic                  bank_free;

    // The compute bank can take a new tile if empty or being released this cycle.
    assign bank_free = !tile_valid || compute_release;
    assign swap_fire = (state == WAIT_SWAP) && bank_free;
    assign in_ready  = (state == FILL);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tiles_left  <= '0;
            addr        <= '0;
            done        <= 1'b0;
            dma_wr_en   <= 1'b0;
            dma_wr_addr <= '0;
            dma_wr_data <= '0;
            swap        <= 1'b0;
            tile_valid  <= 1'b0;
        end else begin
            done      <= 1'b0;
            dma_wr_en <= 1'b0;
            swap      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_tiles != '0) begin
                            tiles_left <= num_tiles;
                            addr       <= '0;
                            state      <= FILL;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        dma_wr_en   <= 1'b1;
                        dma_wr_addr <= addr;
                        dma_wr_data <= in_data;
                        if (addr == LAST_ADDR) begin
                            addr  <= '0;
                            state <= WAIT_SWAP;
                        end else begin
                            addr <= addr + AW'(1);
                        end
                    end
                end
                WAIT_SWAP: begin
                    if (swap_fire) begin
                        swap       <= 1'b1;
                        tiles_left <= tiles_left - TILE_CNT_W'(1);
                        state      <= (tiles_left == TILE_CNT_W'(1)) ? DRAIN : FILL;
                    end
                end
                DRAIN: begin
                    if (bank_free) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A release coinciding with a swap leaves the bank occupied by the new tile.
            if (swap_fire) begin
                tile_valid <= 1'b1;
            end else if (compute_release && tile_valid) begin
                tile_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tile_prefetch_loader.sv
// tb/tb_tile_prefetch_loader.sv - scoreboard bench for tile_prefetch_loader with randomized stream and consumer
module tb_tile_prefetch_loader;

    localparam int BD     = 256;
    localparam int DW     = 8;
    localparam int TW     = 16;
    localparam int BUDGET = 6000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] num_tiles = '0;
    logic          busy;
    logic          done;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          dma_wr_en;
    logic [7:0]    dma_wr_addr;
    logic [DW-1:0] dma_wr_data;
    logic          swap;
    logic          compute_release = 1'b0;
    logic          tile_valid;
    logic [21:0]   outs;

    assign outs = {busy, done, in_ready, dma_wr_en, dma_wr_addr, dma_wr_data, swap, tile_valid};

    tile_prefetch_loader #(.BANK_DEPTH(BD), .DATA_W(DW), .TILE_CNT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
        .busy(busy), .done(done), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .dma_wr_en(dma_wr_en), .dma_wr_addr(dma_wr_addr),
        .dma_wr_data(dma_wr_data), .swap(swap), .compute_release(compute_release),
        .tile_valid(tile_valid)
    );

    typedef struct {
        int          cyc;
        int          addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int job_beats = 0;
    int tile_writes = 0;
    int wr_total = 0;
    int swap_total = 0;
    int done_total = 0;
    int swap_cyc = 0;
    int done_cyc = 0;
    int last_acc_cyc = 0;
    int st_cyc = 0;
    int rel_cyc = 0;
    int rel_req_cnt = 0;
    int drv_mode = 1;
    int pat_mode = 0;
    bit rel_auto = 1'b0;

    initial begin
        forever begin
            #5 clk = 1'b1;
            cyc = cyc + 1;
            #5 clk = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s act=%0d exp=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Stream source: beat pattern addr^0x5A or random data, with a selectable valid duty.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (drv_mode)
                0:       in_valid = 1'b0;
                1:       in_valid = 1'b1;
                2:       in_valid = !in_valid;
                default: in_valid = ($urandom_range(0, 9) < 3);
            endcase
            if (pat_mode == 0) in_data = 8'((job_beats % BD) ^ 8'h5A);
            else               in_data = 8'($urandom);
        end
    end

    // Consumer: explicit release requests from the main sequence, or random releases when enabled.
    initial begin
        int served = 0;
        forever begin
            @(posedge clk);
            #1;
            compute_release = 1'b0;
            if (served < rel_req_cnt) begin
                served = served + 1;
                compute_release = 1'b1;
                rel_cyc = cyc;
            end else if (rel_auto && tile_valid && $urandom_range(0, 3) == 0) begin
                compute_release = 1'b1;
                rel_cyc = cyc;
            end
        end
    end

    // Monitor and scoreboard.
    initial begin
        bit  prev_done = 1'b0;
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                job_beats   = 0;
                tile_writes = 0;
                prev_done   = 1'b0;
            end else begin
                if (dma_wr_en) begin
                    if (exp_q.size() == 0) begin
                        total = total + 1;
                        bad   = bad + 1;
                        $display("FAIL unexpected_write addr=%0d data=%0d (cyc %0d)", dma_wr_addr, dma_wr_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_cycle", cyc, e.cyc);
                        chk("wr_addr", int'(dma_wr_addr), e.addr);
                        chk("wr_data", int'(dma_wr_data), int'(e.data));
                    end
                    wr_total    = wr_total + 1;
                    tile_writes = tile_writes + 1;
                end
                if (swap) begin
                    chk("swap_tile_valid", int'(tile_valid), 1);
                    chk("swap_tile_writes", tile_writes, BD);
                    tile_writes = 0;
                    swap_total  = swap_total + 1;
                    swap_cyc    = cyc;
                end
                if (done) begin
                    chk("done_idle", int'(busy), 0);
                    chk("done_one_cycle", int'(prev_done), 0);
                    done_total = done_total + 1;
                    done_cyc   = cyc;
                end
                prev_done = done;
                if (start && !busy) job_beats = 0;
                if (in_valid && in_ready) begin
                    e.cyc  = cyc + 1;
                    e.addr = job_beats % BD;
                    e.data = in_data;
                    exp_q.push_back(e);
                    job_beats    = job_beats + 1;
                    last_acc_cyc = cyc;
                end
            end
        end
    end

    task automatic pulse_start(input int n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        num_tiles = TW'(n);
        st_cyc    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_swap(input int target, input string name);
        int k = 0;
        while (swap_total < target && k < BUDGET) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (swap_total < target) chk({name, "_swap_timeout"}, swap_total, target);
    endtask

    task automatic wait_done(input int target, input string name);
        int k = 0;
        while (done_total < target && k < BUDGET) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (done_total < target) chk({name, "_done_timeout"}, done_total, target);
    endtask

    task automatic wait_beats(input int target, input string name);
        int k = 0;
        while (job_beats < target && k < BUDGET) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (job_beats < target) chk({name, "_beat_timeout"}, job_beats, target);
    endtask

    initial begin
        #(400000 * 10);
        $display("FAIL watchdog expired (cyc %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, w0, d0;

        // Reset held with the stream offering data.
        drv_mode = 1;
        rst_n    = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("reset_outs", int'(outs), 0);
            chk("reset_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single tile, continuous stream, release ten cycles after the swap.
        s0 = swap_total; w0 = wr_total; d0 = done_total;
        pat_mode = 0;
        pulse_start(1);
        wait_swap(s0 + 1, "t1");
        chk("t1_swap_latency", swap_cyc - last_acc_cyc, 2);
        chk("t1_tile_valid", int'(tile_valid), 1);
        chk("t1_writes", wr_total - w0, BD);
        repeat (10) @(negedge clk);
        rel_req_cnt = rel_req_cnt + 1;
        wait_done(d0 + 1, "t1");
        chk("t1_done_latency", done_cyc - rel_cyc, 1);
        chk("t1_tile_valid_clr", int'(tile_valid), 0);
        @(negedge clk);
        #1;
        chk("t1_done_pulse", int'(done), 0);

        // Three tiles with the consumer holding the compute bank.
        s0 = swap_total; w0 = wr_total; d0 = done_total;
        pat_mode = 1;
        pulse_start(3);
        wait_beats(2 * BD, "bp");
        repeat (5) @(negedge clk);
        #1;
        chk("bp_in_ready_held", int'(in_ready), 0);
        chk("bp_swaps_held", swap_total - s0, 1);
        chk("bp_busy", int'(busy), 1);
        rel_req_cnt = rel_req_cnt + 1;
        wait_swap(s0 + 2, "bp");
        chk("bp_swap_latency", swap_cyc - rel_cyc, 1);
        chk("bp_tile_valid_kept", int'(tile_valid), 1);
        rel_auto = 1'b1;
        wait_done(d0 + 1, "bp");
        chk("bp_swaps", swap_total - s0, 3);
        chk("bp_writes", wr_total - w0, 3 * BD);

        // Alternating valid.
        s0 = swap_total; w0 = wr_total; d0 = done_total;
        drv_mode = 2;
        pulse_start(1);
        wait_done(d0 + 1, "tog");
        chk("tog_writes", wr_total - w0, BD);
        chk("tog_swaps", swap_total - s0, 1);

        // Random 30% valid duty over two tiles.
        s0 = swap_total; w0 = wr_total; d0 = done_total;
        drv_mode = 3;
        pulse_start(2);
        wait_done(d0 + 1, "rnd");
        chk("rnd_writes", wr_total - w0, 2 * BD);
        chk("rnd_swaps", swap_total - s0, 2);

        // Zero tiles completes immediately.
        drv_mode = 1;
        s0 = swap_total; w0 = wr_total; d0 = done_total;
        pulse_start(0);
        wait_done(d0 + 1, "zero");
        chk("zero_done_latency", done_cyc - st_cyc, 1);
        repeat (4) @(negedge clk);
        #1;
        chk("zero_writes", wr_total - w0, 0);
        chk("zero_swaps", swap_total - s0, 0);
        chk("zero_busy", int'(busy), 0);

        // A start while busy must not change the job.
        s0 = swap_total; w0 = wr_total; d0 = done_total;
        pulse_start(1);
        wait_beats(50, "ign");
        pulse_start(5);
        wait_done(d0 + 1, "ign");
        repeat (8) @(negedge clk);
        #1;
        chk("ign_writes", wr_total - w0, BD);
        chk("ign_swaps", swap_total - s0, 1);
        chk("ign_dones", done_total - d0, 1);
        chk("ign_busy", int'(busy), 0);

        // Asynchronous reset in the middle of a fill, then a clean restart.
        pulse_start(1);
        wait_beats(100, "rst");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", int'(outs), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s0 = swap_total; w0 = wr_total; d0 = done_total;
        pulse_start(1);
        wait_done(d0 + 1, "rst");
        chk("rst_restart_writes", wr_total - w0, BD);
        chk("rst_restart_swaps", swap_total - s0, 1);

        repeat (4) @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
